// File: rtl/udp_sched_pkg.sv
// Shared definitions for the UDP transmit scheduler: FSM state encoding,
// header size and the {ch_id, seq} header word layout.
package udp_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARB       = 3'd1,
    ST_START     = 3'd2,
    ST_SEND      = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_GAP       = 3'd5
  } sched_state_e;

  localparam int unsigned HDR_BYTES = 4;

  typedef struct packed {
    logic [14:0] rsvd;
    logic        ch_id;
    logic [15:0] seq;
  } hdr_t;

  function automatic logic [31:0] make_hdr(input logic ch, input logic [15:0] seq);
    hdr_t h;
    h.rsvd  = 15'd0;
    h.ch_id = ch;
    h.seq   = seq;
    return h;
  endfunction

endpackage

// File: rtl/udp_tx_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: the pointed-to requester wins a tie and the
// pointer moves to the other channel whenever a grant is taken.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       gnt_valid_o,
  output logic       gnt_ch_o
);

  logic ptr_q, ptr_d;

  // grant selection and pointer advance
  always_comb begin
    gnt_valid_o = |req_i;
    if (req_i[ptr_q]) begin
      gnt_ch_o = ptr_q;
    end else begin
      gnt_ch_o = ~ptr_q;
    end
    if (take_i && gnt_valid_o) begin
      ptr_d = ~gnt_ch_o;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // pointer register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Shares one UDP transmit path between two FIFO read sides; each packet is a
// {ch_id, seq} header word followed by PKT_WORDS payload words from one channel.
module udp_tx_scheduler
  import udp_sched_pkg::*;
#(
  parameter int unsigned PKT_WORDS   = 256,
  parameter int unsigned LVL_W       = 10,
  parameter int unsigned IPG_CYCLES  = 64,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter logic [15:0] SEQ_INIT    = 16'd0
) (
  input  logic             gmii_tx_clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [LVL_W-1:0] ch0_water_level,
  output logic             ch0_rd_en,
  input  logic [31:0]      ch0_rd_data,
  input  logic [LVL_W-1:0] ch1_water_level,
  output logic             ch1_rd_en,
  input  logic [31:0]      ch1_rd_data,
  output logic             tx_start_en,
  output logic [15:0]      tx_byte_num,
  output logic [31:0]      tx_data,
  input  logic             tx_req,
  input  logic             tx_done,
  output logic             busy,
  output logic             active_ch,
  output logic             timeout_err,
  input  logic             err_clr
);

  localparam int unsigned WCNT_W  = $clog2(PKT_WORDS + 1);
  localparam int unsigned CYC_MAX = (TIMEOUT_CYC > IPG_CYCLES) ? TIMEOUT_CYC : IPG_CYCLES;
  localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);

  localparam logic [15:0]       BYTE_NUM  = 16'(PKT_WORDS * 4 + HDR_BYTES);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(PKT_WORDS);
  localparam logic [CYC_W-1:0]  TMO_LAST  = CYC_W'(TIMEOUT_CYC - 1);
  localparam logic [CYC_W-1:0]  GAP_LAST  = CYC_W'(IPG_CYCLES - 1);
  localparam logic [LVL_W-1:0]  LVL_THR   = LVL_W'(PKT_WORDS);

  sched_state_e      state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic              active_ch_q, active_ch_d;
  logic [15:0]       seq0_q, seq0_d, seq1_q, seq1_d;
  logic              timeout_q, timeout_d;
  logic [15:0]       byte_num_q, byte_num_d;
  logic [31:0]       tx_data_q, tx_data_d;
  logic              rd_pend_q, rd_pend_d;

  logic [1:0]  elig_s;
  logic        gnt_valid_s, gnt_ch_s;
  logic        hdr_req_s, rd_fire_s, done_ok_s, tmo_hit_s;
  logic [31:0] rd_sel_s;

  assign elig_s    = {ch1_water_level >= LVL_THR, ch0_water_level >= LVL_THR};
  assign hdr_req_s = (state_q == ST_SEND) && tx_req && (wcnt_q == '0);
  assign rd_fire_s = (state_q == ST_SEND) && tx_req && (wcnt_q != '0);
  assign done_ok_s = tx_done && ((state_q == ST_SEND) || (state_q == ST_WAIT_DONE));
  assign tmo_hit_s = (state_q == ST_WAIT_DONE) && !tx_done && (cyc_q == TMO_LAST);
  assign rd_sel_s  = active_ch_q ? ch1_rd_data : ch0_rd_data;

  rr_arb2 u_arb (
    .clk_i       (gmii_tx_clk),
    .rst_ni      (rst_n),
    .req_i       (elig_s),
    .take_i      (state_q == ST_ARB),
    .gnt_valid_o (gnt_valid_s),
    .gnt_ch_o    (gnt_ch_s)
  );

  // state register
  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      state_d = (enable && (|elig_s)) ? ST_ARB : ST_IDLE;
      ST_ARB:       state_d = gnt_valid_s ? ST_START : ST_IDLE;
      ST_START:     state_d = ST_SEND;
      ST_SEND: begin
        if (tx_done) begin
          state_d = ST_GAP;
        end else if (tx_req && (wcnt_q == WCNT_LAST)) begin
          state_d = ST_WAIT_DONE;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_WAIT_DONE: state_d = (tx_done || tmo_hit_s) ? ST_GAP : ST_WAIT_DONE;
      ST_GAP:       state_d = (cyc_q == GAP_LAST) ? ST_IDLE : ST_GAP;
      default:      state_d = ST_IDLE;
    endcase
  end

  // counters, sequence numbers, error flag and the tx_data holding register
  always_comb begin
    active_ch_d = active_ch_q;
    byte_num_d  = byte_num_q;
    if ((state_q == ST_ARB) && gnt_valid_s) begin
      active_ch_d = gnt_ch_s;
      byte_num_d  = BYTE_NUM;
    end else begin
      active_ch_d = active_ch_q;
    end

    if (state_q == ST_START) begin
      wcnt_d = '0;
    end else if (hdr_req_s || rd_fire_s) begin
      wcnt_d = wcnt_q + WCNT_W'(1);
    end else begin
      wcnt_d = wcnt_q;
    end

    // one counter serves both the done timeout and the inter-packet gap
    if (state_d != state_q) begin
      cyc_d = '0;
    end else if ((state_q == ST_WAIT_DONE) || (state_q == ST_GAP)) begin
      cyc_d = cyc_q + CYC_W'(1);
    end else begin
      cyc_d = '0;
    end

    seq0_d = seq0_q;
    seq1_d = seq1_q;
    if (done_ok_s) begin
      if (active_ch_q) begin
        seq1_d = seq1_q + 16'd1;
      end else begin
        seq0_d = seq0_q + 16'd1;
      end
    end else begin
      seq0_d = seq0_q;
    end

    if (tmo_hit_s) begin
      timeout_d = 1'b1;
    end else if (err_clr) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end

    // a request that neither sends the header nor reads the FIFO yields zero
    if (hdr_req_s) begin
      tx_data_d = make_hdr(active_ch_q, active_ch_q ? seq1_q : seq0_q);
    end else if (tx_req && !rd_fire_s) begin
      tx_data_d = 32'd0;
    end else if (rd_pend_q) begin
      tx_data_d = rd_sel_s;
    end else begin
      tx_data_d = tx_data_q;
    end
    rd_pend_d = rd_fire_s;
  end

  // datapath registers
  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q      <= '0;
      cyc_q       <= '0;
      active_ch_q <= 1'b0;
      seq0_q      <= SEQ_INIT;
      seq1_q      <= SEQ_INIT;
      timeout_q   <= 1'b0;
      byte_num_q  <= 16'd0;
      tx_data_q   <= 32'd0;
      rd_pend_q   <= 1'b0;
    end else begin
      wcnt_q      <= wcnt_d;
      cyc_q       <= cyc_d;
      active_ch_q <= active_ch_d;
      seq0_q      <= seq0_d;
      seq1_q      <= seq1_d;
      timeout_q   <= timeout_d;
      byte_num_q  <= byte_num_d;
      tx_data_q   <= tx_data_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

  // outputs; FIFO read data is passed straight through in the cycle it arrives
  always_comb begin
    tx_start_en = (state_q == ST_START);
    busy        = (state_q != ST_IDLE);
    ch0_rd_en   = rd_fire_s && !active_ch_q;
    ch1_rd_en   = rd_fire_s && active_ch_q;
    tx_byte_num = byte_num_q;
    active_ch   = active_ch_q;
    timeout_err = timeout_q;
    if (rd_pend_q) begin
      tx_data = rd_sel_s;
    end else begin
      tx_data = tx_data_q;
    end
  end

endmodule
